// File: rtl/ctrl_sequencer_if.sv
// Instruction-side bus between decode and the command sequencer.
// Decode drives the strobes; the sequencer answers with instr_ready.
interface ctrl_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic [27:0] reg_databus;
  logic        begin_rdn_load;
  logic        begin_dnn_load;
  logic        begin_proc;

  modport master (
    output instr_valid,
    output reg_sel,
    output wr_en,
    output reg_databus,
    output begin_rdn_load,
    output begin_dnn_load,
    output begin_proc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  reg_sel,
    input  wr_en,
    input  reg_databus,
    input  begin_rdn_load,
    input  begin_dnn_load,
    input  begin_proc,
    output instr_ready
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Command sequencer: config registers plus start/done sequencing
// of the RDN load, DNN load and processing engines.
module ctrl_sequencer #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  ctrl_sequencer_if.slave        bus,
  output logic                   rdn_start,
  output logic                   dnn_start,
  output logic                   proc_start,
  output logic [27:0]            rdn_addr,
  output logic [27:0]            dnn_addr,
  output logic [27:0]            proc_arg,
  input  logic                   rdn_done,
  input  logic                   dnn_done,
  input  logic                   proc_done,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_not_loaded
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RDN  = 2'd1,
    DNN  = 2'd2,
    PROC = 2'd3
  } state_t;

  state_t      state;
  logic [27:0] cfg_q [4];
  logic [CW-1:0] cnt;
  logic        rdn_loaded;
  logic        dnn_loaded;
  logic        acc;
  logic        wr_acc;
  logic        err_clr;
  logic        eng_done;
  logic        expired;

  // Accept only in IDLE, so config is frozen while an engine runs.
  assign bus.instr_ready = (state == IDLE);
  assign acc     = bus.instr_valid & bus.instr_ready;
  assign wr_acc  = acc & bus.wr_en;
  assign err_clr = wr_acc & (bus.reg_sel == 2'd3)
                 & bus.reg_databus[0];

  assign proc_arg = cfg_q[0];
  assign rdn_addr = cfg_q[1];
  assign dnn_addr = cfg_q[2];
  assign busy     = (state != IDLE);

  // Select the done input belonging to the running engine.
  always_comb begin
    eng_done = 1'b0;
    unique case (state)
      RDN:     eng_done = rdn_done;
      DNN:     eng_done = dnn_done;
      PROC:    eng_done = proc_done;
      default: eng_done = 1'b0;
    endcase
  end

  assign expired = (cnt == LAST) & ~eng_done;

  // Main sequencer: registers, state, flags and start pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
      cnt            <= '0;
      rdn_loaded     <= 1'b0;
      dnn_loaded     <= 1'b0;
      rdn_start      <= 1'b0;
      dnn_start      <= 1'b0;
      proc_start     <= 1'b0;
      err_timeout    <= 1'b0;
      err_not_loaded <= 1'b0;
    end else begin
      rdn_start  <= 1'b0;
      dnn_start  <= 1'b0;
      proc_start <= 1'b0;

      if (wr_acc) cfg_q[bus.reg_sel] <= bus.reg_databus;

      // Clear first so a same-edge set below takes priority.
      if (err_clr) begin
        err_timeout    <= 1'b0;
        err_not_loaded <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (acc) begin
            if (bus.begin_rdn_load) begin
              state      <= RDN;
              rdn_start  <= 1'b1;
              rdn_loaded <= 1'b0;
              cnt        <= '0;
            end else if (bus.begin_dnn_load) begin
              state      <= DNN;
              dnn_start  <= 1'b1;
              dnn_loaded <= 1'b0;
              cnt        <= '0;
            end else if (bus.begin_proc) begin
              if (rdn_loaded && dnn_loaded) begin
                state      <= PROC;
                proc_start <= 1'b1;
                cnt        <= '0;
              end else begin
                err_not_loaded <= 1'b1;
              end
            end
          end
        end
        RDN, DNN, PROC: begin
          if (eng_done) begin
            state <= IDLE;
            if (state == RDN) rdn_loaded <= 1'b1;
            if (state == DNN) dnn_loaded <= 1'b1;
          end else if (expired) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with TIMEOUT=8.
// Expected values are hand-derived from the cycle-level behaviour.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdn_start, dnn_start, proc_start;
  logic [27:0] rdn_addr, dnn_addr, proc_arg;
  logic        rdn_done, dnn_done, proc_done;
  logic        busy, err_timeout, err_not_loaded;

  int n_chk = 0;
  int n_err = 0;

  ctrl_sequencer_if bus ();

  ctrl_sequencer #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .rdn_start      (rdn_start),
    .dnn_start      (dnn_start),
    .proc_start     (proc_start),
    .rdn_addr       (rdn_addr),
    .dnn_addr       (dnn_addr),
    .proc_arg       (proc_arg),
    .rdn_done       (rdn_done),
    .dnn_done       (dnn_done),
    .proc_done      (proc_done),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .err_not_loaded (err_not_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.instr_valid    = 1'b0;
    bus.reg_sel        = 2'd0;
    bus.wr_en          = 1'b0;
    bus.reg_databus    = '0;
    bus.begin_rdn_load = 1'b0;
    bus.begin_dnn_load = 1'b0;
    bus.begin_proc     = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic we,
                       input logic [27:0] d, input logic br,
                       input logic bd, input logic bp);
    bus.instr_valid    = 1'b1;
    bus.reg_sel        = sel;
    bus.wr_en          = we;
    bus.reg_databus    = d;
    bus.begin_rdn_load = br;
    bus.begin_dnn_load = bd;
    bus.begin_proc     = bp;
    tick();
    idle_in();
  endtask

  initial begin
    rst = 1'b1;
    rdn_done = 1'b0;
    dnn_done = 1'b0;
    proc_done = 1'b0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(rdn_addr | dnn_addr | proc_arg), 32'd0);
    chk("rst_err", 32'({err_timeout, err_not_loaded}), 32'd0);
    chk("rst_start", 32'({rdn_start, dnn_start, proc_start}), 32'd0);

    issue(2'd1, 1'b1, 28'h0000123, 1'b0, 1'b0, 1'b0);
    chk("wr_rdn_addr", 32'(rdn_addr), 32'h0000123);
    chk("wr_ready", 32'(bus.instr_ready), 32'd1);
    issue(2'd2, 1'b1, 28'h0ABCDEF, 1'b0, 1'b0, 1'b0);
    chk("wr_dnn_addr", 32'(dnn_addr), 32'h0ABCDEF);
    chk("wr_busy", 32'(busy), 32'd0);

    // RDN load, done 5 cycles after the start cycle
    issue(2'd0, 1'b0, 28'h0, 1'b1, 1'b0, 1'b0);
    chk("rdn_start_s", 32'(rdn_start), 32'd1);
    chk("rdn_ready_s", 32'(bus.instr_ready), 32'd0);
    chk("rdn_busy_s", 32'(busy), 32'd1);
    bus.instr_valid = 1'b1;
    bus.wr_en = 1'b1;
    bus.reg_sel = 2'd1;
    bus.reg_databus = 28'h0000777;
    for (int k = 1; k <= 4; k++) begin
      tick();
      idle_in();
      chk("rdn_start_low", 32'(rdn_start), 32'd0);
      chk("rdn_ready_low", 32'(bus.instr_ready), 32'd0);
    end
    chk("rdn_no_write", 32'(rdn_addr), 32'h0000123);
    tick();
    rdn_done = 1'b1;
    chk("rdn_ready_s5", 32'(bus.instr_ready), 32'd0);
    tick();
    rdn_done = 1'b0;
    chk("rdn_ready_back", 32'(bus.instr_ready), 32'd1);
    chk("rdn_busy_back", 32'(busy), 32'd0);

    // begin_proc with only RDN loaded
    issue(2'd0, 1'b1, 28'h0000055, 1'b0, 1'b0, 1'b1);
    chk("nl_flag", 32'(err_not_loaded), 32'd1);
    chk("nl_busy", 32'(busy), 32'd0);
    chk("nl_pstart", 32'(proc_start), 32'd0);
    chk("nl_arg", 32'(proc_arg), 32'h0000055);
    tick();
    chk("nl_pstart2", 32'(proc_start), 32'd0);
    issue(2'd3, 1'b1, 28'h0000001, 1'b0, 1'b0, 1'b0);
    chk("nl_clear", 32'(err_not_loaded), 32'd0);

    // DNN load, done on the last allowed cycle
    issue(2'd0, 1'b0, 28'h0, 1'b0, 1'b1, 1'b0);
    chk("dnn_start_s", 32'(dnn_start), 32'd1);
    for (int k = 1; k <= 6; k++) tick();
    chk("dnn_busy_s6", 32'(busy), 32'd1);
    tick();
    dnn_done = 1'b1;
    chk("dnn_busy_s7", 32'(busy), 32'd1);
    tick();
    dnn_done = 1'b0;
    chk("dnn_idle", 32'(busy), 32'd0);
    chk("dnn_no_to", 32'(err_timeout), 32'd0);

    // Processing with both loaded, stray rdn_done ignored
    issue(2'd0, 1'b1, 28'h0000040, 1'b0, 1'b0, 1'b1);
    chk("p_arg", 32'(proc_arg), 32'h0000040);
    chk("p_start", 32'(proc_start), 32'd1);
    chk("p_nl", 32'(err_not_loaded), 32'd0);
    tick();
    chk("p_start_low", 32'(proc_start), 32'd0);
    rdn_done = 1'b1;
    tick();
    rdn_done = 1'b0;
    chk("p_stray", 32'(busy), 32'd1);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("p_idle", 32'(busy), 32'd0);
    chk("p_ready", 32'(bus.instr_ready), 32'd1);

    // DNN timeout
    issue(2'd0, 1'b0, 28'h0, 1'b0, 1'b1, 1'b0);
    chk("to_start", 32'(dnn_start), 32'd1);
    for (int k = 1; k <= 7; k++) tick();
    chk("to_busy_s7", 32'(busy), 32'd1);
    chk("to_err_s7", 32'(err_timeout), 32'd0);
    tick();
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err", 32'(err_timeout), 32'd1);
    issue(2'd0, 1'b1, 28'h0000009, 1'b0, 1'b0, 1'b1);
    chk("to_rejected", 32'(err_not_loaded), 32'd1);
    chk("to_rej_busy", 32'(busy), 32'd0);
    issue(2'd3, 1'b1, 28'h0000003, 1'b0, 1'b0, 1'b0);
    chk("clr_both", 32'({err_timeout, err_not_loaded}), 32'd0);

    // DNN done in its start cycle, then PROC and mid-run reset
    issue(2'd0, 1'b0, 28'h0, 1'b0, 1'b1, 1'b0);
    dnn_done = 1'b1;
    chk("fast_start", 32'(dnn_start), 32'd1);
    tick();
    dnn_done = 1'b0;
    chk("fast_idle", 32'(busy), 32'd0);
    issue(2'd0, 1'b1, 28'h0000066, 1'b0, 1'b0, 1'b1);
    chk("r_pstart", 32'(proc_start), 32'd1);
    tick();
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ready", 32'(bus.instr_ready), 32'd1);
    chk("r_addr", 32'(rdn_addr | dnn_addr | proc_arg), 32'd0);
    chk("r_start", 32'({rdn_start, dnn_start, proc_start}), 32'd0);
    tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("r_late_done", 32'(busy), 32'd0);
    chk("r_late_start", 32'(proc_start), 32'd0);
    issue(2'd0, 1'b1, 28'h0000001, 1'b0, 1'b0, 1'b1);
    chk("r_unloaded", 32'(err_not_loaded), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
